// File: rtl/ovl_fire_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ovl_fire_pkg
// Description : Shared types and constants for the OVL fire collector:
//               FSM state encoding and fire-vector bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ovl_fire_pkg;

  // Collector FSM states; the encoding is visible on the state output port
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALT    = 2'd3
  } fsm_state_t;

  // Bit positions inside the OVL fire vector
  localparam int FIRE_2STATE = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER  = 2;
  localparam int FIRE_W      = 3;

endpackage : ovl_fire_pkg
`default_nettype wire

// File: rtl/ovl_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ovl_sat_cnt
// Description : W-bit event counter that sticks at all-ones instead of
//               wrapping; synchronous clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count increments, holding at the maximum value once reached
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : ovl_sat_cnt
`default_nettype wire

// File: rtl/ovl_fire_collector.sv
`default_nettype none
// ============================================================================
// Module      : ovl_fire_collector
// Description : Collects OVL checker fire events into saturating counters,
//               timestamps the first 2-state error, and after MAX_ERR errors
//               runs a drain window before requesting end of test.
// Revision    : 1.0 - initial release
// ============================================================================
module ovl_fire_collector
  import ovl_fire_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  parameter int MAX_ERR      = 1,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [FIRE_W-1:0] i_fire,
  input  logic              i_clear,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_xchk_cnt,
  output logic [CNT_W-1:0]  o_cov_cnt,
  output logic [TS_W-1:0]   o_cycle_cnt,
  output logic              o_first_err_valid,
  output logic [TS_W-1:0]   o_first_err_cycle,
  output logic              o_stop_req,
  output logic [1:0]        o_state
);

  // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit
  localparam int c_DRAIN_W = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
      (DRAIN_CYCLES > 0) ? c_DRAIN_W'(DRAIN_CYCLES - 1) : '0;
  // One extra bit so the threshold compare never truncates the counter
  localparam logic [CNT_W:0] c_MAX_ERR = (CNT_W + 1)'(MAX_ERR);

  fsm_state_t            r_state;
  logic                  r_stop_req;
  logic [c_DRAIN_W-1:0]  r_drain_cnt;
  logic [TS_W-1:0]       r_cycle_cnt;
  logic                  r_first_err_valid;
  logic [TS_W-1:0]       r_first_err_cycle;

  logic                  w_active;
  logic                  w_sample;
  logic                  w_err_hit;
  logic [CNT_W-1:0]      w_cnt [FIRE_W];

  // Fires are sampled only in the live monitoring states; clear wins
  assign w_active  = (r_state == ST_MONITOR) || (r_state == ST_DRAIN);
  assign w_sample  = i_enable && w_active && !i_clear;
  // Threshold is judged on the registered error count
  assign w_err_hit = (MAX_ERR != 0) && ({1'b0, w_cnt[FIRE_2STATE]} >= c_MAX_ERR);

  for (genvar gi = 0; gi < FIRE_W; gi++) begin : g_cnt
    ovl_sat_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_sample && i_fire[gi]),
      .i_clr   (i_clear),
      .o_cnt   (w_cnt[gi])
    );
  end

  // Sequencing FSM: idle -> monitor -> drain window -> halt with stop request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_stop_req  <= 1'b0;
      r_drain_cnt <= '0;
    end else if (i_clear) begin
      r_state     <= ST_IDLE;
      r_stop_req  <= 1'b0;
      r_drain_cnt <= '0;
    end else if (i_enable) begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_MONITOR;
        end
        ST_MONITOR: begin
          if (w_err_hit) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if ((DRAIN_CYCLES == 0) || (r_drain_cnt == c_DRAIN_LAST)) begin
            r_state    <= ST_HALT;
            r_stop_req <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_HALT;
          r_stop_req <= 1'b1;
        end
      endcase
    end
  end

  // Cycle timestamp and one-shot capture of the first 2-state error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_cycle <= '0;
    end else if (i_clear) begin
      r_cycle_cnt       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_cycle <= '0;
    end else if (w_sample) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (i_fire[FIRE_2STATE] && !r_first_err_valid) begin
        r_first_err_valid <= 1'b1;
        r_first_err_cycle <= r_cycle_cnt;
      end
    end
  end

  assign o_err_cnt         = w_cnt[FIRE_2STATE];
  assign o_xchk_cnt        = w_cnt[FIRE_XCHECK];
  assign o_cov_cnt         = w_cnt[FIRE_COVER];
  assign o_cycle_cnt       = r_cycle_cnt;
  assign o_first_err_valid = r_first_err_valid;
  assign o_first_err_cycle = r_first_err_cycle;
  assign o_stop_req        = r_stop_req;
  assign o_state           = r_state;

endmodule : ovl_fire_collector
`default_nettype wire

// File: tb/tb_ovl_fire_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_ovl_fire_collector
// Description : Self-checking bench for ovl_fire_collector. Two instances
//               (default parameters, and a narrow CNT_W=2/TS_W=4/MAX_ERR=0
//               variant) share stimulus and are compared each cycle against
//               an abstract behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ovl_fire_collector;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] fire   = 3'b000;
  logic       clear  = 1'b0;

  logic [15:0] a_err, a_xchk, a_cov;
  logic [31:0] a_cyc, a_fec;
  logic        a_fev, a_stop;
  logic [1:0]  a_state;

  logic [1:0]  b_err, b_xchk, b_cov;
  logic [3:0]  b_cyc, b_fec;
  logic        b_fev, b_stop;
  logic [1:0]  b_state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ovl_fire_collector u_dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_enable (enable), .i_fire (fire), .i_clear (clear),
    .o_err_cnt (a_err), .o_xchk_cnt (a_xchk), .o_cov_cnt (a_cov), .o_cycle_cnt (a_cyc),
    .o_first_err_valid (a_fev), .o_first_err_cycle (a_fec), .o_stop_req (a_stop),
    .o_state (a_state)
  );

  ovl_fire_collector #(.CNT_W(2), .TS_W(4), .MAX_ERR(0), .DRAIN_CYCLES(3)) u_dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_enable (enable), .i_fire (fire), .i_clear (clear),
    .o_err_cnt (b_err), .o_xchk_cnt (b_xchk), .o_cov_cnt (b_cov), .o_cycle_cnt (b_cyc),
    .o_first_err_valid (b_fev), .o_first_err_cycle (b_fec), .o_stop_req (b_stop),
    .o_state (b_state)
  );

  // Abstract model: phase 0=idle 1=monitor 2=drain 3=halt
  typedef struct {
    int     ph;
    longint err, xc, cv, cyc, fec;
    bit     fev;
    int     left;
  } mdl_t;

  mdl_t mA, mB;

  function automatic mdl_t mzero();
    mdl_t z;
    z.ph = 0; z.err = 0; z.xc = 0; z.cv = 0; z.cyc = 0; z.fec = 0; z.fev = 1'b0; z.left = 0;
    return z;
  endfunction

  function automatic longint sat(longint v, longint cmax);
    return (v > cmax) ? cmax : v;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit en, bit [2:0] f, bit clr,
                                 longint cmax, longint tsmod, int maxerr, int dc);
    mdl_t n = m;
    if (clr) return mzero();
    if (!en) return m;
    if (m.ph == 0) begin
      n.ph = 1;
    end else if (m.ph == 1 || m.ph == 2) begin
      if (f[0] && !m.fev) begin
        n.fev = 1'b1;
        n.fec = m.cyc;
      end
      n.err = sat(m.err + longint'(f[0]), cmax);
      n.xc  = sat(m.xc  + longint'(f[1]), cmax);
      n.cv  = sat(m.cv  + longint'(f[2]), cmax);
      n.cyc = (m.cyc + 1) % tsmod;
      if (m.ph == 1) begin
        if (maxerr != 0 && m.err >= maxerr) begin
          n.ph   = 2;
          n.left = dc;
        end
      end else if (m.left <= 1) begin
        n.ph = 3;
      end else begin
        n.left = m.left - 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("A.err",   64'(a_err),   mA.err);
    check("A.xchk",  64'(a_xchk),  mA.xc);
    check("A.cov",   64'(a_cov),   mA.cv);
    check("A.cyc",   64'(a_cyc),   mA.cyc);
    check("A.fev",   64'(a_fev),   64'(mA.fev));
    check("A.fec",   64'(a_fec),   mA.fec);
    check("A.stop",  64'(a_stop),  64'(mA.ph == 3));
    check("A.state", 64'(a_state), 64'(mA.ph));
    check("B.err",   64'(b_err),   mB.err);
    check("B.xchk",  64'(b_xchk),  mB.xc);
    check("B.cov",   64'(b_cov),   mB.cv);
    check("B.cyc",   64'(b_cyc),   mB.cyc);
    check("B.fev",   64'(b_fev),   64'(mB.fev));
    check("B.fec",   64'(b_fec),   mB.fec);
    check("B.stop",  64'(b_stop),  64'(mB.ph == 3));
    check("B.state", 64'(b_state), 64'(mB.ph));
  endtask

  // One clock with the given inputs, model update, then compare off-edge
  task automatic tick(input bit en, input bit [2:0] f, input bit clr);
    enable = en;
    fire   = f;
    clear  = clr;
    @(posedge clk);
    mA = mstep(mA, en, f, clr, 64'hFFFF, 64'h1_0000_0000, 1, 8);
    mB = mstep(mB, en, f, clr, 64'd3, 64'd16, 0, 3);
    #1;
    cmp_all();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    mA = mzero();
    mB = mzero();
    cmp_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    mA = mzero();
    mB = mzero();

    // Reset held across clock edges: everything zero
    #1 rst_n = 1'b0;
    #1 cmp_all();
    repeat (2) @(posedge clk);
    #1 cmp_all();
    rst_n = 1'b1;

    // 10 enabled cycles with no fires
    repeat (10) tick(1'b1, 3'b000, 1'b0);
    check("idle10.cyc",   64'(a_cyc),   64'd9);
    check("idle10.state", 64'(a_state), 64'd1);

    // First error at cycle_cnt=4, drain of 8 enabled cycles then stop
    tick(1'b0, 3'b000, 1'b1);
    tick(1'b1, 3'b000, 1'b0);
    repeat (4) tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b001, 1'b0);
    check("err1.fec", 64'(a_fec), 64'd4);
    check("err1.cnt", 64'(a_err), 64'd1);
    n = 0;
    while (a_state != 2'd2 && n < 5) begin
      tick(1'b1, 3'b000, 1'b0);
      n++;
    end
    check("err1.drain", 64'(a_state), 64'd2);
    n = 0;
    while (!a_stop && n < 20) begin
      if (n == 3) tick(1'b0, 3'b000, 1'b0); // disabled cycle must not count
      tick(1'b1, 3'b000, 1'b0);
      n++;
    end
    check("err1.latency", 64'(n), 64'd8);

    // Saturation on narrow counters, MAX_ERR=0 keeps monitoring
    tick(1'b1, 3'b000, 1'b1);
    tick(1'b1, 3'b000, 1'b0);
    repeat (6) tick(1'b1, 3'b110, 1'b0);
    check("sat.xchk",  64'(b_xchk),  64'd3);
    check("sat.cov",   64'(b_cov),   64'd3);
    check("sat.state", 64'(b_state), 64'd1);

    // Timestamp wrap with TS_W=4
    tick(1'b1, 3'b000, 1'b1);
    repeat (17) tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b001, 1'b0);
    check("wrap.fec", 64'(b_fec), 64'd0);
    check("wrap.fev", 64'(b_fev), 64'd1);

    // Clear beats a simultaneous error fire
    tick(1'b1, 3'b000, 1'b1);
    repeat (3) tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b001, 1'b1);
    check("clr.err",   64'(a_err),   64'd0);
    check("clr.fev",   64'(a_fev),   64'd0);
    check("clr.state", 64'(a_state), 64'd0);

    // Randomized traffic including enable gaps, clears and async resets
    for (int i = 0; i < 800; i++) begin
      bit [2:0] f;
      f    = 3'($urandom);
      f[0] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        tick($urandom_range(0, 9) < 8, f, $urandom_range(0, 39) == 0);
      end
    end

    // Reach HALT, then drop reset: stop_req falls without a clock
    tick(1'b1, 3'b000, 1'b1);
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b001, 1'b0);
    n = 0;
    while (!a_stop && n < 30) begin
      tick(1'b1, 3'b100, 1'b0);
      n++;
    end
    check("halt.stop", 64'(a_stop), 64'd1);
    tick(1'b1, 3'b111, 1'b0);
    check("halt.frozen", 64'(a_err), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.stop",  64'(a_stop),  64'd0);
    check("rst.err",   64'(a_err),   64'd0);
    check("rst.cov",   64'(a_cov),   64'd0);
    check("rst.cyc",   64'(a_cyc),   64'd0);
    check("rst.state", 64'(a_state), 64'd0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_ovl_fire_collector
`default_nettype wire

// File: doc/ovl_fire_collector.md
OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

Interface
REQ-001 Parameter CNT_W, default 16, width of each saturating fire counter.
REQ-002 Parameter TS_W, default 32, width of the cycle counter and the first-error timestamp.
REQ-003 Parameter MAX_ERR, default 1; number of 2-state errors that triggers the drain/stop sequence; 0 disables stop.
REQ-004 Parameter DRAIN_CYCLES, default 8; cycles monitored after MAX_ERR is reached, before stop_req is asserted.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  qualifies fire sampling and cycle counting.
REQ-008 fire  input  3  OVL checker fire vector: bit0 2-state error, bit1 X-check error, bit2 cover event.
REQ-009 clear  input  1  synchronous clear of counters, flags and FSM.
REQ-010 err_cnt  output  CNT_W  count of cycles with fire[0] set.
REQ-011 xchk_cnt  output  CNT_W  count of cycles with fire[1] set.
REQ-012 cov_cnt  output  CNT_W  count of cycles with fire[2] set.
REQ-013 cycle_cnt  output  TS_W  enabled monitor cycles elapsed.
REQ-014 first_err_valid  output  1  sticky flag: a 2-state error has been captured.
REQ-015 first_err_cycle  output  TS_W  cycle_cnt value at the first fire[0].
REQ-016 stop_req  output  1  end-of-test request to the bench.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 The FSM SHALL have four states: IDLE=0, MONITOR=1, DRAIN=2, HALT=3.
REQ-019 IDLE SHALL go to MONITOR on the first cycle with enable=1; that cycle is not sampled.
REQ-020 In MONITOR and DRAIN with enable=1, each fire bit SHALL increment its counter by 1; counting is registered, so the count is visible the cycle after the fire.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 cycle_cnt SHALL increment by 1 per enabled cycle in MONITOR or DRAIN, and SHALL wrap modulo 2^TS_W.
REQ-023 With enable=0, fires SHALL be ignored and cycle_cnt and the drain counter SHALL hold; the state SHALL not change.
REQ-024 On the first sampled fire[0], first_err_cycle SHALL capture the pre-increment cycle_cnt and first_err_valid SHALL set; later errors SHALL NOT overwrite the capture.
REQ-025 MONITOR SHALL go to DRAIN in the cycle the registered err_cnt first becomes >= MAX_ERR, provided MAX_ERR != 0.
REQ-026 DRAIN SHALL count DRAIN_CYCLES enabled cycles, still sampling fires, then go to HALT.
REQ-027 If DRAIN_CYCLES=0, the FSM SHALL go from DRAIN to HALT on the next cycle.
REQ-028 In HALT, stop_req SHALL be 1, counters SHALL freeze, and fires SHALL be ignored.
REQ-029 stop_req SHALL be 0 in every other state.
REQ-030 clear=1 SHALL zero all counters and flags and move the FSM to IDLE from any state; clear wins over a simultaneous fire.
REQ-031 Multiple fire bits in one cycle SHALL each increment their own counter.

Reset
REQ-032 While reset=0, all outputs SHALL be 0 and state SHALL be IDLE, independent of clock.
REQ-033 Reset asserted mid-DRAIN or in HALT SHALL abort immediately and drop stop_req asynchronously.
REQ-034 After reset deasserts, behaviour SHALL be identical to the start after clear.

Structure
REQ-035 Package ovl_fire_pkg SHALL hold the FSM state enum and the fire bit index constants FIRE_2STATE=0, FIRE_XCHECK=1, FIRE_COVER=2.
REQ-036 Sub-module ovl_sat_cnt (parameter W; ports inc, clr; output cnt) SHALL be instantiated three times, once per fire counter.
REQ-037 The drain counter SHALL be sized by $clog2(DRAIN_CYCLES+1), with a minimum width of 1.

Verification
REQ-038 Reset, then enable=1 for 10 cycles with no fires -> state=MONITOR, cycle_cnt=9, all other outputs 0.
REQ-039 Defaults; fire=001 at cycle_cnt=4 -> first_err_cycle=4, err_cnt=1, DRAIN entered, stop_req=1 exactly 8 enabled cycles later.
REQ-040 CNT_W=2, MAX_ERR=0, fire=110 for 6 cycles -> xchk_cnt=3 and cov_cnt=3 (saturated), state stays MONITOR.
REQ-041 TS_W=4, 17 enabled cycles then fire[0] -> first_err_cycle=0 (wrapped).
REQ-042 clear asserted together with fire=001 in MONITOR -> err_cnt=0, first_err_valid=0, state=IDLE.
REQ-043 reset pulsed low while in HALT -> stop_req=0 within the same timestep, all counters 0.
